// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Pipelined, bidirectional barrel shifter. It supports logical shift,
// arithmetic shift and rotate. The shifter is built as SHW binary stages, and
// each stage has a register after it. Stage k shifts by 2^(SHW-1-k), so the
// largest shift happens first. The shift amount, direction and mode travel
// down the pipe with the data, so every stage can decide on its own.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset; clears all stage valids
//   in_valid   in   1      operand present
//   in_ready   out  1      shifter can accept an operand this cycle
//   in_data    in   WIDTH  operand
//   shamt      in   SHW    shift amount, 0..WIDTH-1
//   dir        in   1      1 = left, 0 = right
//   mode       in   2      00 logical, 01 arithmetic, 10 rotate, 11 = logical
//   out_valid  out  1      result present
//   out_ready  in   1      consumer accepts the result
//   out_data   out  WIDTH  result (0 whenever out_valid is 0)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. Once out_valid is asserted, it stays high, and out_data stays stable,
// until out_ready is seen. The whole pipe moves as one unit. When the final
// stage holds a result that has not been taken, every stage freezes and
// in_ready drops. Bubbles are not squeezed out.
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] MODE_ARITH  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;

    // Stage registers
    logic             r_valid [SHW];
    logic [WIDTH-1:0] r_data  [SHW];
    logic [SHW-1:0]   r_shamt [SHW];
    logic             r_dir   [SHW];
    logic [1:0]       r_mode  [SHW];

    // Per-stage inputs (previous stage register, or the ports for stage 0)
    logic             w_in_valid [SHW];
    logic [WIDTH-1:0] w_in_data  [SHW];
    logic [SHW-1:0]   w_in_shamt [SHW];
    logic             w_in_dir   [SHW];
    logic [1:0]       w_in_mode  [SHW];
    logic [WIDTH-1:0] w_out_data [SHW];

    logic             w_adv;

    // Fixed-distance shift used by one stage. Rotation is taken from the
    // doubled word, so the bits leaving one end come back in at the other end.
    // Arithmetic right keeps the MSB. Because of that, every later stage sees
    // the original sign bit.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input int               amt,
        input logic             left,
        input logic [1:0]       md
    );
        logic [2*WIDTH-1:0] dd;
        logic [WIDTH-1:0]   res;
        dd = {d, d};
        if (md == MODE_ROTATE) begin
            if (left) begin
                dd  = dd << amt;
                res = dd[2*WIDTH-1:WIDTH];
            end else begin
                dd  = dd >> amt;
                res = dd[WIDTH-1:0];
            end
        end else if (left) begin
            res = d << amt;
        end else if (md == MODE_ARITH) begin
            res = $signed(d) >>> amt;
        end else begin
            res = d >> amt;
        end
        return res;
    endfunction

    assign w_adv     = !r_valid[SHW-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[SHW-1];
    assign out_data  = r_valid[SHW-1] ? r_data[SHW-1] : '0;

    always_comb begin
        w_in_valid[0] = in_valid;
        w_in_data[0]  = in_data;
        w_in_shamt[0] = shamt;
        w_in_dir[0]   = dir;
        w_in_mode[0]  = mode;
        for (int k = 1; k < SHW; k++) begin
            w_in_valid[k] = r_valid[k-1];
            w_in_data[k]  = r_data[k-1];
            w_in_shamt[k] = r_shamt[k-1];
            w_in_dir[k]   = r_dir[k-1];
            w_in_mode[k]  = r_mode[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            // Stage k looks at shamt bit SHW-1-k. The MSB goes first.
            if (w_in_shamt[k][SHW-1-k]) begin
                w_out_data[k] = stage_shift(w_in_data[k], 1 << (SHW - 1 - k),
                                            w_in_dir[k], w_in_mode[k]);
            end else begin
                w_out_data[k] = w_in_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_dir[k]   <= 1'b0;
                r_mode[k]  <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= w_in_valid[k];
                // Payload loads only for a real operation. The registers of a
                // bubble keep their old contents.
                if (w_in_valid[k]) begin
                    r_data[k]  <= w_out_data[k];
                    r_shamt[k] <= w_in_shamt[k];
                    r_dir[k]   <= w_in_dir[k];
                    r_mode[k]  <= w_in_mode[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

    localparam int W   = 8;
    localparam int SHW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [SHW-1:0] shamt;
    logic           dir;
    logic [1:0]     mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_out    = 0;
    logic [W-1:0] exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         acc;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .shamt     (shamt),
        .dir       (dir),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bit-by-bit reference for the whole shift
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SHW-1:0] s,
                                           input logic left, input logic [1:0] m);
        logic [W-1:0] r;
        int sh;
        sh = int'(s);
        for (int i = 0; i < W; i++) begin
            if (m == 2'b10)
                r[i] = left ? d[(i - sh + W) % W] : d[(i + sh) % W];
            else if (left)
                r[i] = (i >= sh) ? d[i - sh] : 1'b0;
            else
                r[i] = (i + sh < W) ? d[i + sh] : ((m == 2'b01) ? d[W-1] : 1'b0);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One cycle of streaming: drive on negedge, check handshake/scoreboard, wait edge
    task automatic step(input logic v, input logic [W-1:0] d, input logic [SHW-1:0] s,
                        input logic dr, input logic [1:0] m, input logic ordy,
                        output logic accepted);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        shamt     = s;
        dir       = dr;
        mode      = m;
        out_ready = ordy;
        #1;
        if (prev_stall) begin
            check("hold_valid", {7'b0, out_valid}, 8'd1);
            check("hold_data", out_data, prev_data);
        end
        if (out_valid && !out_ready)
            check("stall_in_ready", {7'b0, in_ready}, 8'd0);
        else
            check("adv_in_ready", {7'b0, in_ready}, 8'd1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("spurious_out", {7'b0, out_valid}, 8'd0);
            else
                check("out_data", out_data, exp_q.pop_front());
            n_out++;
        end
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(model(d, s, dr, m));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        @(posedge clk);
    endtask

    task automatic drain();
        int budget;
        logic a;
        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            step(1'b0, '0, '0, 1'b0, 2'b00, 1'b1, a);
            budget++;
        end
        check("drain_empty", {7'b0, exp_q.size() == 0}, 8'd1);
    endtask

    // Single operation with explicit latency checks
    task automatic directed(input string tag, input logic [W-1:0] d, input logic [SHW-1:0] s,
                            input logic dr, input logic [1:0] m, input logic [W-1:0] expv);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; shamt = s; dir = dr; mode = m; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, {7'b0, in_ready}, 8'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_lat1"}, {7'b0, out_valid}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_lat2"}, {7'b0, out_valid}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, {7'b0, out_valid}, 8'd1);
        check(tag, out_data, expv);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_gone"}, {7'b0, out_valid}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; shamt = '0; dir = 1'b0;
        mode = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {7'b0, out_valid}, 8'd0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_in_ready", {7'b0, in_ready}, 8'd1);

        // Directed vectors
        directed("lsl3",       8'h96, 3'd3, 1'b1, 2'b00, 8'hB0);
        directed("asr2",       8'h96, 3'd2, 1'b0, 2'b01, 8'hE5);
        directed("lsr2",       8'h96, 3'd2, 1'b0, 2'b00, 8'h25);
        directed("ror4",       8'h96, 3'd4, 1'b0, 2'b10, 8'h69);
        directed("rol1",       8'h81, 3'd1, 1'b1, 2'b10, 8'h03);
        directed("rol7",       8'h81, 3'd7, 1'b1, 2'b10, 8'hC0);
        directed("rsv_r2",     8'h96, 3'd2, 1'b0, 2'b11, 8'h25);
        directed("asl1",       8'h96, 3'd1, 1'b1, 2'b01, 8'h2C);
        directed("asr7_pos",   8'h7F, 3'd7, 1'b0, 2'b01, 8'h00);
        directed("asr7_neg",   8'h80, 3'd7, 1'b0, 2'b01, 8'hFF);
        directed("sh0_rot",    8'h96, 3'd0, 1'b1, 2'b10, 8'h96);
        directed("sh0_asr",    8'h96, 3'd0, 1'b0, 2'b01, 8'h96);

        // Streaming: 10 operands, out_ready low for 5 cycles mid-stream
        begin
            int idx;
            logic [W-1:0] d;
            n_out = 0;
            idx   = 0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                d = W'(8'h13 * idx + 8'h5A);
                step(idx < 10, d, SHW'(idx % 8), idx[0], 2'(idx % 4),
                     !(cyc >= 4 && cyc < 9), acc);
                if (acc) idx++;
            end
            drain();
            check("stream_count", 8'(n_out), 8'd10);
        end

        // Reset mid-stream with 2 operands in flight
        step(1'b1, 8'h96, 3'd3, 1'b1, 2'b00, 1'b1, acc);
        step(1'b1, 8'h81, 3'd1, 1'b1, 2'b10, 1'b1, acc);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("flush_out_valid", {7'b0, out_valid}, 8'd0);
        check("flush_out_data", out_data, 8'h00);
        check("flush_in_ready", {7'b0, in_ready}, 8'd1);
        exp_q.delete();
        prev_stall = 1'b0;
        repeat (6) step(1'b0, '0, '0, 1'b0, 2'b00, 1'b1, acc);

        // Exhaustive sweep with random backpressure
        for (int d = 0; d < 256; d++) begin
            for (int s = 0; s < 8; s++) begin
                for (int dr = 0; dr < 2; dr++) begin
                    for (int m = 0; m < 4; m++) begin
                        int tries;
                        tries = 0;
                        do begin
                            step(1'b1, W'(d), SHW'(s), dr[0], 2'(m),
                                 $urandom_range(0, 3) != 0, acc);
                            tries++;
                        end while (!acc && tries < 20);
                        if (!acc) check("sweep_accept_timeout", 8'd0, 8'd1);
                    end
                end
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
